// File: rtl/mem_wb_stage_if.sv
// Bundle between the MEM stage, data-memory response and the MEM/WB stage.
// The master side drives the instruction and memory response; the slave is the stage.
interface mem_wb_stage_if #(
  parameter int OP_W  = 7,
  parameter int REG_W = 5
);
  logic              in_valid;
  logic [OP_W-1:0]   in_opcode;
  logic              in_we;
  logic [REG_W-1:0]  in_rd;
  logic [1:0]        in_wb_sel;
  logic [63:0]       in_alu_result;
  logic [63:0]       in_pc_plus4;
  logic [63:0]       in_csr_data;
  logic [2:0]        in_funct3;
  logic [2:0]        in_addr_lsb;
  logic              in_branch;
  logic              in_pred_ok;
  logic              flush;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;
  logic              stall_out;
  logic              we;
  logic [REG_W-1:0]  writeRegister;
  logic [63:0]       writeData;
  logic [OP_W-1:0]   opcode;
  logic              branchOp;
  logic              validPrediction;
  logic              load_fault;

  modport master (
    output in_valid, in_opcode, in_we, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_csr_data, in_funct3, in_addr_lsb, in_branch,
           in_pred_ok, flush, mem_rvalid, mem_rdata,
    input  stall_out, we, writeRegister, writeData, opcode, branchOp,
           validPrediction, load_fault
  );

  modport slave (
    input  in_valid, in_opcode, in_we, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_csr_data, in_funct3, in_addr_lsb, in_branch,
           in_pred_ok, flush, mem_rvalid, mem_rdata,
    output stall_out, we, writeRegister, writeData, opcode, branchOp,
           validPrediction, load_fault
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: waits for load data, aligns/extends it, selects the writeback value
// and registers one retirement (or bubble) per cycle; abandons loads after MEM_TIMEOUT.
module mem_wb_stage #(
  parameter int MEM_TIMEOUT = 255,
  parameter int OP_W        = 7,
  parameter int REG_W       = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_wait_cnt_nxt;
  logic              w_is_load;
  logic              w_cnt_hit;
  logic              w_retire;
  logic              w_stall;
  logic              w_timeout;
  logic              w_illegal;
  logic              w_fault;
  logic [63:0]       w_load_data;
  logic [63:0]       w_wb_data;

  logic              r_we;
  logic [REG_W-1:0]  r_rd;
  logic [63:0]       r_wdata;
  logic [OP_W-1:0]   r_opcode;
  logic              r_branch;
  logic              r_pred;
  logic              r_fault;

  // Offset is cleared to natural alignment for the access size before shifting.
  function automatic logic [63:0] f_align(input logic [63:0] rdata,
                                          input logic [2:0]  funct3,
                                          input logic [2:0]  lsb);
    logic [2:0]  off;
    logic [63:0] sh;
    case (funct3[1:0])
      2'b00:   off = lsb;
      2'b01:   off = {lsb[2:1], 1'b0};
      2'b10:   off = {lsb[2], 2'b00};
      default: off = 3'b000;
    endcase
    sh = rdata >> {off, 3'b000};
    case (funct3)
      3'b000:  f_align = {{56{sh[7]}},  sh[7:0]};
      3'b001:  f_align = {{48{sh[15]}}, sh[15:0]};
      3'b010:  f_align = {{32{sh[31]}}, sh[31:0]};
      3'b011:  f_align = sh;
      3'b100:  f_align = {56'h0, sh[7:0]};
      3'b101:  f_align = {48'h0, sh[15:0]};
      3'b110:  f_align = {32'h0, sh[31:0]};
      default: f_align = 64'h0;
    endcase
  endfunction

  assign w_is_load   = (bus.in_wb_sel == 2'b01);
  assign w_cnt_hit   = (r_wait_cnt == 8'(MEM_TIMEOUT));
  assign w_load_data = f_align(bus.mem_rdata, bus.in_funct3, bus.in_addr_lsb);

  // Writeback source select.
  always_comb begin
    w_wb_data = 64'h0;
    case (bus.in_wb_sel)
      2'b00:   w_wb_data = bus.in_alu_result;
      2'b01:   w_wb_data = w_load_data;
      2'b10:   w_wb_data = bus.in_pc_plus4;
      default: w_wb_data = bus.in_csr_data;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush && w_is_load && !bus.mem_rvalid) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end else begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end
      end
      S_WAIT: begin
        if (bus.flush || bus.mem_rvalid || w_cnt_hit) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Per-cycle decision: retire, stall, or timeout; anything else is a bubble.
  always_comb begin
    w_retire  = 1'b0;
    w_stall   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.in_valid || bus.flush) begin
          w_retire = 1'b0;
        end else if (!w_is_load || bus.mem_rvalid) begin
          w_retire = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.flush) begin
          w_retire = 1'b0;
        end else if (bus.mem_rvalid) begin
          w_retire = 1'b1;
        end else if (w_cnt_hit) begin
          w_timeout = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  assign w_illegal = w_retire && w_is_load && (bus.in_funct3 == 3'b111);
  assign w_fault   = w_timeout || w_illegal;

  // Retirement registers; a bubble keeps writeRegister/writeData unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_rd     <= {REG_W{1'b0}};
      r_wdata  <= 64'h0;
      r_opcode <= {OP_W{1'b0}};
      r_branch <= 1'b0;
      r_pred   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_fault <= w_fault;
      if (w_retire) begin
        r_we     <= bus.in_we && !w_illegal;
        r_rd     <= bus.in_rd;
        r_wdata  <= w_illegal ? 64'h0 : w_wb_data;
        r_opcode <= bus.in_opcode;
        r_branch <= bus.in_branch;
        r_pred   <= bus.in_pred_ok;
      end else begin
        r_we     <= 1'b0;
        r_opcode <= {OP_W{1'b0}};
        r_branch <= 1'b0;
        r_pred   <= 1'b0;
      end
    end
  end

  assign bus.stall_out       = w_stall;
  assign bus.we              = r_we;
  assign bus.writeRegister   = r_rd;
  assign bus.writeData       = r_wdata;
  assign bus.opcode          = r_opcode;
  assign bus.branchOp        = r_branch;
  assign bus.validPrediction = r_pred;
  assign bus.load_fault      = r_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of single-cycle vectors plus hand-written
// multi-cycle sequences; expectations travel through a scoreboard queue.
module tb_mem_wb_stage;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  mem_wb_stage_if #(.OP_W(7), .REG_W(5)) bus ();

  mem_wb_stage #(.MEM_TIMEOUT(4), .OP_W(7), .REG_W(5)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic [63:0] csr;
    logic [2:0]  f3;
    logic [2:0]  lsb;
    logic        br;
    logic        pred;
    logic        flush;
    logic        rvalid;
    logic [63:0] rdata;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_wd;
    logic [6:0]  e_op;
    logic        e_br;
    logic        e_pred;
    logic        e_fault;
    logic        e_chkd;
  } vec_t;

  localparam logic [63:0] R = 64'h1122_3344_8899_AABB;

  vec_t exp_q[$];
  vec_t tbl[17];

  function automatic vec_t v_bub();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t to_bubble(input vec_t vi);
    vec_t v;
    v = vi;
    v.e_stall = 1'b0; v.e_we = 1'b0; v.e_op = 7'h00; v.e_br = 1'b0;
    v.e_pred = 1'b0; v.e_fault = 1'b0; v.e_chkd = 1'b0;
    return v;
  endfunction

  function automatic vec_t v_alu(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [1:0] sel, input logic [63:0] val);
    vec_t v;
    v = v_bub();
    v.valid = 1'b1; v.op = op; v.we = 1'b1; v.rd = rd; v.sel = sel;
    v.alu = 64'hA1A1_A1A1_A1A1_A1A1;
    v.pc4 = 64'hB2B2_B2B2_B2B2_B2B2;
    v.csr = 64'hC3C3_C3C3_C3C3_C3C3;
    v.rdata = 64'hD4D4_D4D4_D4D4_D4D4;
    case (sel)
      2'b00:   v.alu = val;
      2'b10:   v.pc4 = val;
      default: v.csr = val;
    endcase
    v.e_we = 1'b1; v.e_rd = rd; v.e_wd = val; v.e_op = op; v.e_chkd = 1'b1;
    return v;
  endfunction

  // Load from IDLE: a response retires it, otherwise it stalls as a bubble.
  function automatic vec_t v_ld(input logic [2:0] f3, input logic [2:0] lsb,
                                input logic [63:0] rdata, input logic rvalid,
                                input logic [4:0] rd, input logic [63:0] exp_wd);
    vec_t v;
    v = v_bub();
    v.valid = 1'b1; v.op = 7'h03; v.we = 1'b1; v.rd = rd; v.sel = 2'b01;
    v.alu = 64'hA1A1_A1A1_A1A1_A1A1;
    v.f3 = f3; v.lsb = lsb; v.rdata = rdata; v.rvalid = rvalid;
    if (rvalid) begin
      v.e_we = 1'b1; v.e_rd = rd; v.e_wd = exp_wd; v.e_op = 7'h03; v.e_chkd = 1'b1;
    end else begin
      v.e_stall = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    e = exp_q.pop_front();
    chk({tag, " we"},    64'(bus.we),              64'(e.e_we));
    chk({tag, " op"},    64'(bus.opcode),          64'(e.e_op));
    chk({tag, " br"},    64'(bus.branchOp),        64'(e.e_br));
    chk({tag, " pred"},  64'(bus.validPrediction), 64'(e.e_pred));
    chk({tag, " fault"}, 64'(bus.load_fault),      64'(e.e_fault));
    if (e.e_chkd) begin
      chk({tag, " rd"}, 64'(bus.writeRegister), 64'(e.e_rd));
      chk({tag, " wd"}, bus.writeData,          e.e_wd);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid      = v.valid;
    bus.in_opcode     = v.op;
    bus.in_we         = v.we;
    bus.in_rd         = v.rd;
    bus.in_wb_sel     = v.sel;
    bus.in_alu_result = v.alu;
    bus.in_pc_plus4   = v.pc4;
    bus.in_csr_data   = v.csr;
    bus.in_funct3     = v.f3;
    bus.in_addr_lsb   = v.lsb;
    bus.in_branch     = v.br;
    bus.in_pred_ok    = v.pred;
    bus.flush         = v.flush;
    bus.mem_rvalid    = v.rvalid;
    bus.mem_rdata     = v.rdata;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " stall"}, 64'(bus.stall_out), 64'(v.e_stall));
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    vec_t v;
    vec_t w;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    drive(v_bub());

    tbl[0]  = v_alu(7'h33, 5'd5, 2'b00, 64'h1234);
    tbl[1]  = v_bub();
    tbl[2]  = v_ld(3'b000, 3'd2, 64'h0000_0000_0080_FF00, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    v = v_alu(7'h6F, 5'd1, 2'b10, 64'h1004);
    v.br = 1'b1; v.pred = 1'b1; v.e_br = 1'b1; v.e_pred = 1'b1;
    tbl[3]  = v;
    tbl[4]  = v_alu(7'h73, 5'd3, 2'b11, 64'hDEAD_BEEF_0000_0001);
    tbl[5]  = v_ld(3'b001, 3'd3, R, 1'b1, 5'd8,  64'hFFFF_FFFF_FFFF_8899);
    tbl[6]  = v_ld(3'b010, 3'd5, R, 1'b1, 5'd10, 64'h0000_0000_1122_3344);
    tbl[7]  = v_ld(3'b011, 3'd7, R, 1'b1, 5'd11, R);
    tbl[8]  = v_ld(3'b100, 3'd1, R, 1'b1, 5'd12, 64'h0000_0000_0000_00AA);
    tbl[9]  = v_ld(3'b110, 3'd0, R, 1'b1, 5'd13, 64'h0000_0000_8899_AABB);
    tbl[10] = v_ld(3'b010, 3'd4, 64'h8000_0001_0000_0000, 1'b1, 5'd14, 64'hFFFF_FFFF_8000_0001);
    v = v_ld(3'b111, 3'd0, R, 1'b1, 5'd9, 64'h0);
    v.e_we = 1'b0; v.e_fault = 1'b1;
    tbl[11] = v;
    v = v_ld(3'b000, 3'd0, R, 1'b0, 5'd4, 64'h0);
    v.flush = 1'b1;
    tbl[12] = to_bubble(v);
    v = v_bub();
    v.rvalid = 1'b1; v.rdata = R;
    tbl[13] = v;
    v = v_ld(3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 1'b1, 5'd15, 64'h0000_0000_0000_BEEF);
    v.we = 1'b0; v.e_we = 1'b0;
    tbl[14] = v;
    tbl[15] = v_alu(7'h13, 5'd0, 2'b00, 64'h55);
    tbl[16] = v_ld(3'b101, 3'd5, R, 1'b1, 5'd16, 64'h0000_0000_0000_3344);

    @(posedge clk);
    #1;
    chk("reset we",    64'(bus.we),              64'h0);
    chk("reset op",    64'(bus.opcode),          64'h0);
    chk("reset rd",    64'(bus.writeRegister),   64'h0);
    chk("reset wd",    bus.writeData,            64'h0);
    chk("reset br",    64'(bus.branchOp),        64'h0);
    chk("reset pred",  64'(bus.validPrediction), 64'h0);
    chk("reset fault", 64'(bus.load_fault),      64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // LHU with response on the fourth cycle: three stall cycles.
    w = v_ld(3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 1'b0, 5'd20, 64'h0);
    for (int i = 0; i < 3; i++) apply(w, $sformatf("lhu_wait%0d", i));
    apply(v_ld(3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 1'b1, 5'd20, 64'h0000_0000_0000_BEEF), "lhu_resp");

    // Timeout: four stall cycles, then a fault bubble, then IDLE again.
    w = v_ld(3'b000, 3'd0, R, 1'b0, 5'd21, 64'h0);
    for (int i = 0; i < 4; i++) apply(w, $sformatf("to_wait%0d", i));
    v = w; v.e_stall = 1'b0; v.e_fault = 1'b1;
    apply(v, "to_fault");
    apply(v_alu(7'h33, 5'd6, 2'b00, 64'h77), "to_after");

    // Flush in WAIT wins over a simultaneous response.
    apply(w, "fl_wait");
    v = v_ld(3'b000, 3'd0, R, 1'b1, 5'd21, 64'h0);
    v.flush = 1'b1;
    apply(to_bubble(v), "fl_flush");
    apply(v_alu(7'h33, 5'd6, 2'b00, 64'h77), "fl_after");

    // Async reset mid-WAIT clears outputs immediately.
    apply(w, "rst_wait");
    @(negedge clk);
    reset_n = 1'b0;
    drive(v_bub());
    #1;
    chk("rst_now rd", 64'(bus.writeRegister), 64'h0);
    chk("rst_now wd", bus.writeData,          64'h0);
    chk("rst_now we", 64'(bus.we),            64'h0);
    chk("rst_now op", 64'(bus.opcode),        64'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_rel stall", 64'(bus.stall_out),  64'h0);
    chk("rst_rel fault", 64'(bus.load_fault), 64'h0);
    apply(v_alu(7'h33, 5'd2, 2'b00, 64'h99), "rst_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
